// File: rtl/systolic_core_if.sv
// systolic_core_if: bundles the run handshake and operand/result buses of
// systolic_core.
//   start       master->slave  begin a run (sampled only while idle)
//   in_x_flat   master->slave  N row operands, row r at [(r+1)*D_W-1 -: D_W]
//   in_y_flat   master->slave  N column operands, column c at [(c+1)*D_W-1 -: D_W]
//   busy        slave->master  high while accumulating
//   done        slave->master  one-cycle pulse when results are final
//   out_z_flat  slave->master  N*N accumulators, Z[r][c] at index r*N+c
interface systolic_core_if #(
  parameter int unsigned D_W   = 8,
  parameter int unsigned N     = 2,
  parameter int unsigned ACC_W = 19
) ();
  logic                   start;
  logic [N*D_W-1:0]       in_x_flat;
  logic [N*D_W-1:0]       in_y_flat;
  logic                   busy;
  logic                   done;
  logic [N*N*ACC_W-1:0]   out_z_flat;

  modport master (
    output start, in_x_flat, in_y_flat,
    input  busy, done, out_z_flat
  );

  modport slave (
    input  start, in_x_flat, in_y_flat,
    output busy, done, out_z_flat
  );
endinterface

// File: rtl/systolic_core.sv
// systolic_core: output-stationary N x N multiply-accumulate array.
// Row operands enter the left edge and shift right one PE per cycle; column
// operands enter the top edge and shift down one PE per cycle. Each PE keeps
// its own accumulator, exposed directly on out_z_flat.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  systolic_core_if.slave (start, in_x_flat, in_y_flat, busy, done,
//        out_z_flat)
module systolic_core #(
  parameter int unsigned D_W     = 8,
  parameter int unsigned N       = 2,
  parameter int unsigned WORD    = 8,
  parameter int unsigned ACC_W   = 2 * D_W + $clog2(WORD),
  parameter int unsigned RUN_CYC = WORD + 2 * N
) (
  input logic             clk,
  input logic             rst,
  systolic_core_if.slave  bus
);

  localparam int unsigned CNT_W = (RUN_CYC > 1) ? $clog2(RUN_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYC - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             clr;     // accepted start: zero accumulators and pipes
  logic             run_en;  // accumulate/shift this cycle

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    run_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      S_RUN: begin
        run_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        // start is not looked at here, so a start in the final RUN cycle is
        // dropped rather than chaining a new run.
        if (cnt_q == LAST_CNT) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = done_q;

  // Registered pipe outputs of every PE, visible to the right/lower neighbour.
  logic [D_W-1:0] x_pipe [N][N];
  logic [D_W-1:0] y_pipe [N][N];

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [D_W-1:0]   x_in, y_in;
      logic [D_W-1:0]   x_q, y_q;
      logic [ACC_W-1:0] acc_q;
      logic [2*D_W-1:0] prod;

      if (c == 0) begin : g_x_edge
        assign x_in = bus.in_x_flat[r*D_W +: D_W];
      end else begin : g_x_pipe
        assign x_in = x_pipe[r][c-1];
      end

      if (r == 0) begin : g_y_edge
        assign y_in = bus.in_y_flat[c*D_W +: D_W];
      end else begin : g_y_pipe
        assign y_in = y_pipe[r-1][c];
      end

      assign prod = x_in * y_in;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          x_q   <= '0;
          y_q   <= '0;
          acc_q <= '0;
        end else if (run_en) begin
          x_q   <= x_in;
          y_q   <= y_in;
          acc_q <= acc_q + ACC_W'(prod);
        end
      end

      assign x_pipe[r][c] = x_q;
      assign y_pipe[r][c] = y_q;
      assign bus.out_z_flat[(r*N+c)*ACC_W +: ACC_W] = acc_q;
    end
  end

endmodule

// File: tb/tb_systolic_core.sv
// tb_systolic_core: directed-vector bench for systolic_core with a behavioural
// model. The model records the edge operands of each run and forms every
// Z[r][c] as a sum over cycles of (row r value seen c cycles earlier) times
// (column c value seen r cycles earlier), modulo 2^ACC_W; busy/done follow the
// run-length rule. Outputs are compared against it on every falling edge.
module tb_systolic_core;
  localparam int D_W     = 8;
  localparam int N       = 2;
  localparam int WORD    = 8;
  localparam int ACC_W   = 19;
  localparam int RUN_CYC = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_core_if #(.D_W(D_W), .N(N), .ACC_W(ACC_W)) bus ();

  systolic_core #(
    .D_W(D_W), .N(N), .WORD(WORD), .ACC_W(ACC_W), .RUN_CYC(RUN_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nvec  = 0;
  int nfail = 0;
  int ndone = 0;

  // stimulus tables, indexed by RUN cycle
  int sx [RUN_CYC][N];
  int sy [RUN_CYC][N];
  bit sst [RUN_CYC];
  int srst;

  // model state
  int left = 0;
  int idx;
  int s;
  bit m_busy, m_done, m_zvalid;
  bit chk_en = 1'b0;
  int bx [RUN_CYC][N];
  int by [RUN_CYC][N];
  int mz [N][N];

  function automatic logic [N*N*ACC_W-1:0] pack_mz();
    logic [N*N*ACC_W-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[(r*N+c)*ACC_W +: ACC_W] = ACC_W'(mz[r][c]);
    return v;
  endfunction

  function automatic int dut_z(int r, int c);
    logic [ACC_W-1:0] t;
    t = bus.out_z_flat[(r*N+c)*ACC_W +: ACC_W];
    return int'(t);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      left = 0;
      m_done = 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) mz[r][c] = 0;
      m_zvalid = 1'b1;
    end else begin
      m_done = (left == 1);
      if (left > 0) begin
        idx = RUN_CYC - left;
        for (int r = 0; r < N; r++) begin
          bx[idx][r] = int'(bus.in_x_flat[r*D_W +: D_W]);
          by[idx][r] = int'(bus.in_y_flat[r*D_W +: D_W]);
        end
        left = left - 1;
        if (left == 0) begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
              s = 0;
              for (int t = 0; t < RUN_CYC; t++)
                if (t >= c && t >= r) s = s + bx[t-c][r] * by[t-r][c];
              mz[r][c] = s % (1 << ACC_W);
            end
          m_zvalid = 1'b1;
        end
      end else if (bus.start === 1'b1) begin
        left = RUN_CYC;
        m_zvalid = 1'b0;
      end
    end
    m_busy = (left > 0);
    chk_en = 1'b1;
  end

  task automatic check_bit(string nm, logic a, logic e);
    nvec++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_bit("busy", bus.busy, m_busy);
      check_bit("done", bus.done, m_done);
      if (m_zvalid) begin
        nvec++;
        if (bus.out_z_flat !== pack_mz()) begin
          nfail++;
          $display("FAIL out_z_flat: got %h expected %h at %0t",
                   bus.out_z_flat, pack_mz(), $time);
        end
      end
      if (bus.done === 1'b1) ndone++;
    end
  end

  // hand-computed literals pin both the DUT and the model
  task automatic check_lit(string nm, int r, int c, int val);
    nvec++;
    if (dut_z(r, c) != val) begin
      nfail++;
      $display("FAIL %s Z%0d%0d: got %0d expected %0d", nm, r, c, dut_z(r, c), val);
    end
    nvec++;
    if (mz[r][c] != val) begin
      nfail++;
      $display("FAIL %s model Z%0d%0d: got %0d expected %0d", nm, r, c, mz[r][c], val);
    end
  endtask

  task automatic check_count(string nm, int got, int exp);
    nvec++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < RUN_CYC; i++) begin
      sst[i] = 1'b0;
      for (int r = 0; r < N; r++) begin
        sx[i][r] = 0;
        sy[i][r] = 0;
      end
    end
    srst = -1;
  endtask

  task automatic set_lanes(int i);
    for (int r = 0; r < N; r++) begin
      bus.in_x_flat[r*D_W +: D_W] = D_W'(sx[i][r]);
      bus.in_y_flat[r*D_W +: D_W] = D_W'(sy[i][r]);
    end
  endtask

  // Starts in the current cycle, drives RUN_CYC RUN cycles, returns early in
  // the cycle after the last RUN cycle (the done cycle).
  task automatic run_vec();
    bus.start = 1'b1;
    bus.in_x_flat = '0;
    bus.in_y_flat = '0;
    @(posedge clk); #1;
    for (int i = 0; i < RUN_CYC; i++) begin
      set_lanes(i);
      bus.start = sst[i];
      rst = (i == srst);
      @(posedge clk); #1;
    end
    bus.in_x_flat = '0;
    bus.in_y_flat = '0;
    bus.start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic idle(int n, bit garbage);
    for (int i = 0; i < n; i++) begin
      bus.start = 1'b0;
      bus.in_x_flat = garbage ? (N*D_W)'($urandom) : '0;
      bus.in_y_flat = garbage ? (N*D_W)'($urandom) : '0;
      @(posedge clk); #1;
    end
  endtask

  task automatic set_matmul();
    int xm [2][2];
    int ym [2][2];
    xm = '{'{1, 2}, '{3, 4}};
    ym = '{'{5, 6}, '{7, 8}};
    clear_stim();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++) begin
        sx[k+r][r] = xm[r][k];
        sy[k+r][r] = ym[k][r];
      end
  endtask

  task automatic check_matmul(string nm);
    check_lit(nm, 0, 0, 19);
    check_lit(nm, 0, 1, 22);
    check_lit(nm, 1, 0, 43);
    check_lit(nm, 1, 1, 50);
  endtask

  int d0;

  initial begin
    rst = 1'b1;
    bus.start = 1'b1;
    bus.in_x_flat = (N*D_W)'($urandom);
    bus.in_y_flat = (N*D_W)'($urandom);
    @(posedge clk); #1;
    bus.in_x_flat = (N*D_W)'($urandom);
    bus.in_y_flat = (N*D_W)'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    idle(1, 1'b0);
    check_lit("reset", 0, 0, 0);
    check_lit("reset", 1, 1, 0);

    // single product
    clear_stim();
    sx[0][0] = 3; sy[0][0] = 5;
    d0 = ndone;
    run_vec();
    check_lit("single", 0, 0, 15);
    check_lit("single", 0, 1, 0);
    check_lit("single", 1, 0, 0);
    check_lit("single", 1, 1, 0);
    idle(3, 1'b0);
    check_count("single done count", ndone - d0, 1);

    // 2x2 matmul, then results must hold through idle cycles
    set_matmul();
    run_vec();
    check_matmul("matmul");
    idle(5, 1'b1);
    check_matmul("matmul hold");

    // wrap, followed by a back-to-back start in the done cycle
    clear_stim();
    for (int i = 0; i < RUN_CYC; i++) begin
      sx[i][0] = 255; sy[i][0] = 255;
    end
    run_vec();
    check_lit("wrap", 0, 0, 256012);
    check_lit("wrap", 1, 1, 0);
    clear_stim();
    sx[0][0] = 3; sy[0][0] = 5;
    run_vec();
    check_lit("back2back", 0, 0, 15);
    idle(2, 1'b0);

    // start pulses while busy and in the final RUN cycle are ignored
    set_matmul();
    sst[3] = 1'b1;
    sst[RUN_CYC-1] = 1'b1;
    d0 = ndone;
    run_vec();
    check_matmul("start while busy");
    idle(3, 1'b0);
    check_count("start while busy done count", ndone - d0, 1);

    // reset mid-run, then a fresh run
    set_matmul();
    srst = 5;
    d0 = ndone;
    run_vec();
    idle(2, 1'b0);
    check_count("mid-run reset done count", ndone - d0, 0);
    check_lit("mid-run reset", 0, 0, 0);
    check_lit("mid-run reset", 1, 1, 0);
    set_matmul();
    run_vec();
    check_matmul("after reset");
    idle(2, 1'b0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
